// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single-outstanding memory reads into a PC-tagged FIFO.
// Optional FETCH_PERF_EN adds saturating fetch_cnt/drop_cnt outputs.
module instr_fetch_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  output logic              pc_inc,
  input  logic              flush,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
`ifdef FETCH_PERF_EN
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       drop_cnt,
`endif
  output logic [DATA_W-1:0] instr_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] req_pc_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] tag_q  [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic latch;
  logic push;
  logic pop;
  logic drop;

  assign mem_addr    = req_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr_out   = data_q[rd_ptr_q];
  assign instr_pc    = tag_q[rd_ptr_q];
  assign pop         = instr_valid && instr_ready;

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    push    = 1'b0;
    drop    = 1'b0;
    mem_req = 1'b0;
    pc_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && count_q != FULL) begin
          state_d = REQ;
          latch   = 1'b1;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (flush) begin
          state_d = mem_gnt ? DROP : IDLE;
        end else if (mem_gnt) begin
          pc_inc  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          drop    = mem_rvalid;
          state_d = mem_rvalid ? IDLE : DROP;
        end else if (mem_rvalid) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (mem_rvalid) begin
          drop    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) req_pc_q <= pc_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= mem_rdata;
        tag_q[wr_ptr_q]  <= req_pc_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating; flush deliberately leaves them alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 1'b1;
      if (drop && drop_cnt != 16'hFFFF)  drop_cnt  <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a counter and memory responder.
// Popped words are logged at the clock edge and compared to fixed addresses.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc = 16'h0;
  logic [15:0] ld_val = 16'h0;
  logic        ld = 1'b0;
  logic        flush = 1'b0;
  logic        gnt_en = 1'b0;
  logic        rsp_hold = 1'b0;
  logic        ready = 1'b0;
  logic        pend = 1'b0;
  logic [15:0] paddr = 16'h0;
  int          inc_cnt = 0;
  int          rsp_cnt = 0;
  logic [31:0] log_q[$];
  int          checks = 0;
  int          errors = 0;

  logic        pc_inc, mem_req, mem_gnt, mem_rvalid, instr_valid;
  logic [15:0] mem_addr, mem_rdata, instr_out, instr_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  assign mem_gnt    = mem_req & gnt_en;
  assign mem_rvalid = pend & ~rsp_hold;
  assign mem_rdata  = paddr ^ 16'hA5A5;

  instr_fetch_unit #(.DATA_W(16), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc),
    .pc_inc      (pc_inc),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (ready),
    .instr_out   (instr_out),
`ifdef FETCH_PERF_EN
    .fetch_cnt   (fetch_cnt),
    .drop_cnt    (drop_cnt),
`endif
    .instr_pc    (instr_pc)
  );

  // Program counter, memory responder and pop logger.
  always @(posedge clk) begin
    if (ld) pc <= ld_val;
    else if (pc_inc) pc <= pc + 16'd1;
    if (pc_inc) inc_cnt <= inc_cnt + 1;
    if (mem_req && mem_gnt) begin
      pend  <= 1'b1;
      paddr <= mem_addr;
    end else if (mem_rvalid) begin
      pend    <= 1'b0;
      rsp_cnt <= rsp_cnt + 1;
    end
    if (rst && instr_valid && ready) log_q.push_back({instr_pc, instr_out});
  end

  function automatic logic [31:0] ent(input logic [15:0] a);
    return {a, a ^ 16'hA5A5};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    @(negedge clk);
    while (!mem_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("req_to", 32'(mem_req), 32'd1);
  endtask

  task automatic wait_rv();
    int k;
    k = 0;
    while (!mem_rvalid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rv_to", 32'(mem_rvalid), 32'd1);
  endtask

  task automatic wait_pend();
    int k;
    k = 0;
    while (!pend && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("pend_to", 32'(pend), 32'd1);
  endtask

  task automatic wait_rsp(input int n);
    int k;
    k = 0;
    while (rsp_cnt < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rsp_to", 32'(rsp_cnt >= n), 32'd1);
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (log_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("log_to", 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_flush(input logic [15:0] v);
    @(negedge clk);
    flush  = 1'b1;
    ld     = 1'b1;
    ld_val = v;
    @(negedge clk);
    flush = 1'b0;
    ld    = 1'b0;
  endtask

  initial begin
    int lb;
    int i0;
    int r0;
    logic [15:0] p0;

    ld     = 1'b1;
    ld_val = 16'h0000;
    ready  = 1'b1;
    gnt_en = 1'b1;
    cycles(2);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_inc", 32'(pc_inc), 32'd0);
    check("rst_vld", 32'(instr_valid), 32'd0);
    check("rst_out", 32'(instr_out), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);
    ld  = 1'b0;
    rst = 1'b1;

    // Streaming with single-cycle gnt and rvalid.
    wait_log(3);
    gnt_en = 1'b0;
    cycles(6);
    check("t1_w0", log_q[0], 32'h0000_A5A5);
    check("t1_w1", log_q[1], 32'h0001_A5A4);
    check("t1_w2", log_q[2], 32'h0002_A5A7);
    check("t1_inc", 32'(inc_cnt), 32'(log_q.size()));

    // Backpressure: FIFO fills to DEPTH, then drains in order.
    lb     = log_q.size();
    p0     = pc;
    i0     = inc_cnt;
    ready  = 1'b0;
    gnt_en = 1'b1;
    cycles(30);
    check("t2_inc", 32'(inc_cnt - i0), 32'd4);
    check("t2_req", 32'(mem_req), 32'd0);
    check("t2_vld", 32'(instr_valid), 32'd1);
    ready = 1'b1;
    wait_log(lb + 6);
    for (int i = 0; i < 6; i++)
      check("t2_ord", log_q[lb+i], ent(p0 + 16'(i)));

    // Delayed grant: request held stable, pc_inc only on the grant cycle.
    gnt_en = 1'b0;
    cycles(6);
    load_flush(16'h0010);
    wait_req();
    i0 = inc_cnt;
    for (int i = 0; i < 3; i++) begin
      check("t3_req", 32'(mem_req), 32'd1);
      check("t3_addr", 32'(mem_addr), 32'h10);
      check("t3_noinc", 32'(pc_inc), 32'd0);
      @(negedge clk);
    end
    gnt_en = 1'b1;
    #1;
    check("t3_inc", 32'(pc_inc), 32'd1);
    @(negedge clk);
    gnt_en = 1'b0;
    check("t3_incn", 32'(inc_cnt - i0), 32'd1);
    cycles(6);

    // Flush in WAIT with a counter load.
    load_flush(16'h0020);
    rsp_hold = 1'b1;
    wait_req();
    check("t4_addr", 32'(mem_addr), 32'h20);
    lb     = log_q.size();
    gnt_en = 1'b1;
    @(negedge clk);
    gnt_en = 1'b0;
    flush  = 1'b1;
    ld     = 1'b1;
    ld_val = 16'hAAAA;
    @(negedge clk);
    flush    = 1'b0;
    ld       = 1'b0;
    rsp_hold = 1'b0;
    @(negedge clk);
    check("t4_vld", 32'(instr_valid), 32'd0);
    wait_req();
    check("t4_naddr", 32'(mem_addr), 32'hAAAA);
    check("t4_nolog", 32'(log_q.size() - lb), 32'd0);
`ifdef FETCH_PERF_EN
    check("t4_drop", 32'(drop_cnt), 32'd1);
`endif

    // Simultaneous push/pop at count 2, across pointer wrap.
    lb    = log_q.size();
    ready = 1'b0;
    load_flush(16'h0030);
    gnt_en = 1'b1;
    r0     = rsp_cnt;
    wait_rsp(r0 + 2);
    for (int i = 0; i < 4; i++) begin
      wait_rv();
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
    end
    gnt_en = 1'b0;
    check("t5_pops", 32'(log_q.size() - lb), 32'd4);
    for (int i = 0; i < 4; i++)
      check("t5_ord", log_q[lb+i], ent(16'h0030 + 16'(i)));
    cycles(4);
    ready = 1'b1;
    cycles(8);
    check("t5_left", 32'(log_q.size() - lb), 32'd6);
    check("t5_w4", log_q[lb+4], ent(16'h0034));
    check("t5_w5", log_q[lb+5], ent(16'h0035));

    // Async reset mid-WAIT with 3 buffered words, then orphan response.
    lb    = log_q.size();
    ready = 1'b0;
    load_flush(16'h0040);
    gnt_en = 1'b1;
    r0     = rsp_cnt;
    wait_rsp(r0 + 3);
    rsp_hold = 1'b1;
    wait_pend();
    check("t6_vld", 32'(instr_valid), 32'd1);
    rst    = 1'b0;
    ld     = 1'b1;
    ld_val = 16'h0050;
    #1;
    check("t6_req", 32'(mem_req), 32'd0);
    check("t6_addr", 32'(mem_addr), 32'd0);
    check("t6_inc", 32'(pc_inc), 32'd0);
    check("t6_vld0", 32'(instr_valid), 32'd0);
    check("t6_out", 32'(instr_out), 32'd0);
    check("t6_pc", 32'(instr_pc), 32'd0);
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    rsp_hold = 1'b0;
    ready    = 1'b1;
    wait_log(lb + 1);
    check("t6_restart", log_q[lb], ent(16'h0050));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
